bcd_serial_addsub: RTL and testbench



---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_digit_cell.sv | 30 +++
 rtl/bcd_serial_addsub.sv | 161 ++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial BCD add/subtract datapath.
`timescale 1ns/1ps
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Nines' complement of one digit; used to turn a-b into a + ~b + 1 in decimal.
  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return BCD_MAX - d;
  endfunction

  // True when a raw 4-bit code is not a legal decimal digit.
  function automatic logic digit_invalid(input bcd_digit_t d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One-digit BCD adder with decimal correction; reused every cycle by the serial top.
`timescale 1ns/1ps
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t i_a,
  input  bcd_digit_t i_b,
  input  logic       i_cin,
  output bcd_digit_t o_sum,
  output logic       o_cout
);

  logic [4:0] w_t;

  assign w_t = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};

  // Binary sum above nine wraps into the next decade: add six and raise the carry.
  always_comb begin
    o_sum  = w_t[3:0];
    o_cout = 1'b0;
    if (w_t > {1'b0, BCD_MAX}) begin
      o_sum  = w_t[3:0] + BCD_CORR;
      o_cout = 1'b1;
    end else begin
      o_sum  = w_t[3:0];
      o_cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional build macro BCD_ERR_CHECK_EN adds the err port flagging non-decimal
// input digits captured at accept.
`timescale 1ns/1ps
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                ready,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout
`ifdef BCD_ERR_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

  state_t          r_state;
  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_cout;
  logic            r_done;
  logic [CW-1:0]   r_cnt;

  bcd_digit_t      w_dig_a;
  bcd_digit_t      w_dig_b;
  bcd_digit_t      w_dig_sum;
  logic            w_dig_cout;
  logic [W-1:0]    w_b_nc;
  logic            w_accept;
  logic            w_last;

  assign ready    = (r_state == IDLE);
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_cnt == LAST_IDX);

  // Pick the operand digits addressed by the digit counter.
  always_comb begin
    w_dig_a = 4'd0;
    w_dig_b = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_cnt == CW'(k)) begin
        w_dig_a = r_op_a[4*k +: 4];
        w_dig_b = r_op_b[4*k +: 4];
      end else begin
        w_dig_a = w_dig_a;
        w_dig_b = w_dig_b;
      end
    end
  end

  // Per-digit nines' complement of b, captured instead of b when subtracting.
  always_comb begin
    w_b_nc = {W{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      w_b_nc[4*k +: 4] = nines_comp(b[4*k +: 4]);
    end
  end

  bcd_digit_cell u_cell (
    .i_a    (w_dig_a),
    .i_b    (w_dig_b),
    .i_cin  (r_carry),
    .o_sum  (w_dig_sum),
    .o_cout (w_dig_cout)
  );

  // Control FSM and datapath: capture operands on accept, then walk the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op_a  <= {W{1'b0}};
      r_op_b  <= {W{1'b0}};
      r_sum   <= {W{1'b0}};
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op_a  <= a;
            r_op_b  <= sub ? w_b_nc : b;
            r_carry <= sub;
            r_cnt   <= {CW{1'b0}};
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          for (int k = 0; k < DIGITS; k++) begin
            if (r_cnt == CW'(k)) begin
              r_sum[4*k +: 4] <= w_dig_sum;
            end
          end
          r_carry <= w_dig_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout  <= w_dig_cout;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef BCD_ERR_CHECK_EN
  logic r_err;
  logic w_bad_digit;

  assign err = r_err;

  // Any non-decimal code among the raw operand digits presented with start.
  always_comb begin
    w_bad_digit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_invalid(a[4*k +: 4]) || digit_invalid(b[4*k +: 4])) begin
        w_bad_digit = 1'b1;
      end else begin
        w_bad_digit = w_bad_digit;
      end
    end
  end

  // Sticky error flag, refreshed at every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_bad_digit;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4), scoreboard based.
`timescale 1ns/1ps
module tb_bcd_serial_addsub;

  localparam int D = 4;
  localparam int MOD = 10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        done;
  logic [15:0] sum;
  logic        cout;
`ifdef BCD_ERR_CHECK_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef BCD_ERR_CHECK_EN
    ,
    .err   (err)
`endif
  );

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = 16'h0000;
    int t = n;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference model working on plain integers.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic s);
    exp_t e;
    int r;
    if (s) r = bcd2int(av) - bcd2int(bv) + MOD;
    else   r = bcd2int(av) + bcd2int(bv);
    e.sum  = int2bcd(r % MOD);
    e.cout = (r >= MOD);
    e.err  = 1'b0;
    return e;
  endfunction

  // Called at a negedge; start is seen by the following posedge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic s,
                          input exp_t e, input bit push);
    a = av; b = bv; sub = s; start = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int rdy_low, output bit seen);
    cyc = 0; rdy_low = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (!ready) rdy_low++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 16'h0; b = 16'h0;
    #3;
    n_cmp++;
    if ({ready, done, sum, cout} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got ready=%b done=%b sum=%h cout=%b, want 1 0 0000 0",
               ready, done, sum, cout);
    end
`ifdef BCD_ERR_CHECK_EN
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub;
    logic [15:0] ta [6] = '{16'h1234, 16'h9999, 16'h0005, 16'h5000, 16'h0123, 16'h0000};
    logic [15:0] tb [6] = '{16'h5678, 16'h0001, 16'h0005, 16'h1234, 16'h0456, 16'h0000};
    logic        ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] xs [6] = '{16'h6912, 16'h0000, 16'h0010, 16'h3766, 16'h9667, 16'h0000};
    logic        xc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int cyc, rl;
    bit seen;
    exp_t e, g;
    for (int i = 0; i < 6; i++) begin
      e.sum = xs[i]; e.cout = xc[i]; e.err = 1'b0;
      start_op(ta[i], tb[i], ts[i], e, 1'b1);
      wait_done(cyc, rl, seen);
      g = sb.pop_front();
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL directed_timeout[%0d]: no done within 20 cycles", i); end
      n_cmp++;
      if (cyc !== 5 || rl !== 4) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: got done@%0d ready_low=%0d, want 5 and 4", i, cyc, rl);
      end
      n_cmp++;
      if (sum !== g.sum || cout !== g.cout) begin
        n_bad++;
        $display("FAIL directed_result[%0d]: got sum=%h cout=%b, want sum=%h cout=%b",
                 i, sum, cout, g.sum, g.cout);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || ready !== 1'b1 || sum !== g.sum || cout !== g.cout) begin
        n_bad++;
        $display("FAIL directed_hold[%0d]: got done=%b ready=%b sum=%h cout=%b, want 0 1 %h %b",
                 i, done, ready, sum, cout, g.sum, g.cout);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] av, bv;
    logic s;
    int cyc, rl;
    bit seen;
    exp_t g;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < D; k++) begin
        av[4*k +: 4] = 4'($urandom_range(0, 9));
        bv[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      s = 1'($urandom_range(0, 1));
      start_op(av, bv, s, model(av, bv, s), 1'b1);
      wait_done(cyc, rl, seen);
      g = sb.pop_front();
      n_cmp++;
      if (!seen || sum !== g.sum || cout !== g.cout) begin
        n_bad++;
        $display("FAIL random[%0d] %h %s %h: got done=%b sum=%h cout=%b, want sum=%h cout=%b",
                 i, av, s ? "-" : "+", bv, seen, sum, cout, g.sum, g.cout);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc, rl;
    bit seen;
    exp_t g;
    start_op(16'h1234, 16'h5678, 1'b0, model(16'h1234, 16'h5678, 1'b0), 1'b1);
    @(negedge clk);
    a = 16'h9999; b = 16'h9999; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, rl, seen);
    g = sb.pop_front();
    n_cmp++;
    if (!seen || cyc !== 3 || sum !== g.sum || cout !== g.cout) begin
      n_bad++;
      $display("FAIL ignore_start: got done=%b at +%0d sum=%h cout=%b, want done at +3 sum=%h cout=%b",
               seen, cyc, sum, cout, g.sum, g.cout);
    end
    // Still in the done cycle: issue the next operation immediately.
    start_op(16'h0005, 16'h0005, 1'b0, model(16'h0005, 16'h0005, 1'b0), 1'b1);
    wait_done(cyc, rl, seen);
    g = sb.pop_front();
    n_cmp++;
    if (!seen || cyc !== 5 || sum !== g.sum || cout !== g.cout) begin
      n_bad++;
      $display("FAIL back_to_back: got done=%b at %0d sum=%h cout=%b, want done at 5 sum=%h cout=%b",
               seen, cyc, sum, cout, g.sum, g.cout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit seen;
    e = '0;
    start_op(16'h1234, 16'h5678, 1'b0, e, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ready, done, sum, cout} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: got ready=%b done=%b sum=%h cout=%b, want 1 0 0000 0",
               ready, done, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_no_done: got done_seen=%b ready=%b, want 0 1", seen, ready);
    end
  endtask

`ifdef BCD_ERR_CHECK_EN
  task automatic test_err;
    int cyc, rl;
    bit seen;
    exp_t e, g;
    e = '0; e.err = 1'b1;
    start_op(16'h00A3, 16'h0001, 1'b0, e, 1'b1);
    wait_done(cyc, rl, seen);
    g = sb.pop_front();
    n_cmp++;
    if (!seen || err !== g.err) begin
      n_bad++;
      $display("FAIL err_set: got done=%b err=%b, want done=1 err=1", seen, err);
    end
    @(negedge clk);
    start_op(16'h0001, 16'h0001, 1'b0, model(16'h0001, 16'h0001, 1'b0), 1'b1);
    wait_done(cyc, rl, seen);
    g = sb.pop_front();
    n_cmp++;
    if (!seen || err !== 1'b0 || sum !== g.sum) begin
      n_bad++;
      $display("FAIL err_clear: got done=%b err=%b sum=%h, want 1 0 %h", seen, err, sum, g.sum);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_add_sub();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef BCD_ERR_CHECK_EN
    test_err();
`endif
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
